fpu_norm_round: RTL and testbench

Pipelined normalise-round-pack stage of the floating-point datapath, directly downstream of the significand adder/subtractor. Takes the raw 27-bit significand result, the adder carry, the operation path, the sign and the larger operand's biased exponent. It renormalises, rounds and packs an IEEE-754 single-precision word. Two register stages with a valid/ready handshake, full throughput, and backpressure support.

---
 rtl/fpu_norm_round.sv | 176 +++++++++++++++++
 tb/tb_fpu_norm_round.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_norm_round.sv
// fpu_norm_round: renormalise, round and pack the significand adder result into an IEEE-754 single.
// Latency 2 cycles (stage N then stage R), one beat per cycle; FPU_NORM_RNE_EN selects round-to-nearest-even, else truncate.
// Backpressure: in_ready drops combinationally from out_ready when both stages hold a beat; no skid buffer.
module fpu_norm_round #(
    parameter int EXP_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [26:0] in_mant,
    input  logic        in_carry,
    input  logic        in_add_path,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [2:0]  out_flags
);

    typedef struct packed {
        logic [26:0]      mant;
        logic [EXP_W-1:0] exp;
        logic             sign;
        logic             zero;
        logic             uf;
    } norm_t;

    localparam logic signed [EXP_W-1:0] EXP_ONE = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] EXP_INF = EXP_W'(255);

    logic        n_valid_q, n_valid_d;
    logic        r_valid_q, r_valid_d;
    norm_t       n_q, n_d;
    logic [31:0] result_q, result_d;
    logic [2:0]  flags_q, flags_d;

    logic n_adv;
    logic r_adv;

    assign r_adv      = !r_valid_q || out_ready;
    assign n_adv      = !n_valid_q || r_adv;
    assign in_ready   = n_adv;
    assign out_valid  = r_valid_q;
    assign out_result = result_q;
    assign out_flags  = flags_q;

    // ---------------------------------------------------------------
    // Stage N: leading-zero count and renormalisation
    // ---------------------------------------------------------------
    logic [4:0] lz;

    // Scanning upward lets the highest set bit win; 27 is the all-zero value.
    always_comb begin
        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (in_mant[i]) begin
                lz = 5'(26 - i);
            end
        end
    end

    logic signed [EXP_W-1:0] in_exp_s;
    logic signed [EXP_W-1:0] lz_s;
    logic signed [EXP_W-1:0] nx_exp;
    logic [26:0]             nx_mant;
    logic                    nx_sign;
    logic                    nx_zero;
    logic                    nx_uf;

    assign in_exp_s = EXP_W'(in_exp);
    assign lz_s     = EXP_W'(lz);

    always_comb begin
        nx_mant = in_mant << lz;
        nx_exp  = in_exp_s - lz_s;
        nx_sign = in_sign;
        nx_zero = 1'b0;
        if (in_add_path && in_carry) begin
            // Shift right one place, folding the dropped bit into sticky.
            nx_mant = {1'b1, in_mant[26:2], in_mant[1] | in_mant[0]};
            nx_exp  = in_exp_s + EXP_ONE;
        end else if (in_mant == '0) begin
            nx_mant = '0;
            nx_exp  = '0;
            nx_sign = in_add_path & in_sign;
            nx_zero = 1'b1;
        end
        nx_uf = !nx_zero && (nx_exp < EXP_ONE);
    end

    always_comb begin
        n_valid_d = n_valid_q;
        n_d       = n_q;
        if (n_adv) begin
            n_valid_d = in_valid;
            if (in_valid) begin
                n_d.mant = nx_mant;
                n_d.exp  = nx_exp;
                n_d.sign = nx_sign;
                n_d.zero = nx_zero;
                n_d.uf   = nx_uf;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage R: round, exponent adjust, pack
    // ---------------------------------------------------------------
    logic                    rnd_inc;
    logic                    rnd_carry;
    logic                    inexact;
    logic [22:0]             frac;
    logic signed [EXP_W-1:0] r_exp;
    logic [31:0]             pack_res;
    logic [2:0]              pack_flags;

    always_comb begin
`ifdef FPU_NORM_RNE_EN
        rnd_inc = n_q.mant[2] & (n_q.mant[1] | n_q.mant[0] | n_q.mant[3]);
`else
        rnd_inc = 1'b0;
`endif
        // Hidden bit is always set on a normalised beat, so a carry out of
        // 24 bits means every significand bit was one; frac then wraps to 0.
        rnd_carry = rnd_inc & n_q.mant[26] & (&n_q.mant[25:3]);
        frac      = n_q.mant[25:3] + {22'd0, rnd_inc};
        r_exp     = $signed(n_q.exp);
        if (rnd_carry) begin
            r_exp = r_exp + EXP_ONE;
        end
        inexact = |n_q.mant[2:0];

        if (n_q.zero || n_q.uf) begin
            pack_res   = {n_q.sign, 31'd0};
            pack_flags = {1'b0, n_q.uf, n_q.uf};
        end else if (r_exp >= EXP_INF) begin
            pack_res   = {n_q.sign, 8'hFF, 23'd0};
            pack_flags = 3'b101;
        end else begin
            pack_res   = {n_q.sign, r_exp[7:0], frac};
            pack_flags = {2'b00, inexact};
        end
    end

    always_comb begin
        r_valid_d = r_valid_q;
        result_d  = result_q;
        flags_d   = flags_q;
        if (r_adv) begin
            r_valid_d = n_valid_q;
            if (n_valid_q) begin
                result_d = pack_res;
                flags_d  = pack_flags;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_valid_q <= 1'b0;
            r_valid_q <= 1'b0;
            n_q       <= '0;
            result_q  <= 32'h0000_0000;
            flags_q   <= 3'b000;
        end else begin
            n_valid_q <= n_valid_d;
            r_valid_q <= r_valid_d;
            n_q       <= n_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
        end
    end

endmodule

// File: tb/tb_fpu_norm_round.sv
// Bench for fpu_norm_round: directed vector table, backpressure and reset sequences,
// and a randomized stream scored against an arithmetic reference model.
module tb_fpu_norm_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [26:0] in_mant;
    logic        in_carry;
    logic        in_add_path;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    always #5 clk = ~clk;

    fpu_norm_round #(.EXP_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mant    (in_mant),
        .in_carry   (in_carry),
        .in_add_path(in_add_path),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    typedef struct {
        string       name;
        logic [26:0] mant;
        logic        carry;
        logic        add;
        logic        sign;
        logic [7:0]  exp;
        logic [31:0] res;
        logic [2:0]  flags;
    } vec_t;

    vec_t        vq[$];
    logic [34:0] sb[$];
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: treat {carry, mant} as an integer, locate its MSB, and read the
    // 24-bit significand plus guard/rest straight off the scaled value.
    function automatic logic [34:0] model(input logic [26:0] m, input logic c, input logic a,
                                          input logic s, input logic [7:0] e);
        logic [63:0] v;
        logic [63:0] w;
        logic [24:0] sig;
        logic        g;
        logic        rest;
        logic        inc;
        int          p;
        int          ex;
        v = 64'(m);
        if (a && c) v = v | (64'd1 << 27);
        if (v == 64'd0) return {3'b000, (a ? s : 1'b0), 31'd0};
        p = 27;
        while (v[p] == 1'b0) p--;
        ex = int'(e) + p - 26;
        if (ex < 1) return {3'b011, s, 31'd0};
        w    = v << (40 - p);
        sig  = {1'b0, w[40:17]};
        g    = w[16];
        rest = |w[15:0];
`ifdef FPU_NORM_RNE_EN
        inc = g && (rest || sig[0]);
`else
        inc = 1'b0;
`endif
        sig = sig + 25'(inc);
        if (sig[24]) begin
            sig = 25'h080_0000;
            ex++;
        end
        if (ex >= 255) return {3'b101, s, 8'hFF, 23'd0};
        return {2'b00, g | rest, s, 8'(ex), sig[22:0]};
    endfunction

    task automatic add_vec(input string n, input logic [26:0] m, input logic c, input logic a,
                           input logic s, input logic [7:0] e, input logic [31:0] r, input logic [2:0] f);
        vec_t v;
        v.name = n; v.mant = m; v.carry = c; v.add = a; v.sign = s; v.exp = e; v.res = r; v.flags = f;
        vq.push_back(v);
    endtask

    // One cycle: settle, score any handshakes, advance to just after the next edge.
    task automatic step(output bit fin, output bit fout);
        logic [34:0] e;
        #1;
        fin  = in_valid && in_ready;
        fout = out_valid && out_ready;
        if (fout) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got %h expected none", {out_flags, out_result});
            end else begin
                e = sb.pop_front();
                check("stream", {out_flags, out_result}, e);
            end
        end
        if (fin) sb.push_back(model(in_mant, in_carry, in_add_path, in_sign, in_exp));
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        in_mant = v.mant; in_carry = v.carry; in_add_path = v.add; in_sign = v.sign; in_exp = v.exp;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({v.name, "_in_ready"}, 35'(in_ready), 35'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({v.name, "_lat1"}, 35'(out_valid), 35'd0);
        @(posedge clk);
        #1;
        check({v.name, "_lat2"}, 35'(out_valid), 35'd1);
        check({v.name, "_result"}, {out_flags, out_result}, {v.flags, v.res});
        @(posedge clk);
        #1;
    endtask

    task automatic new_beat();
        in_add_path = 1'($urandom_range(0, 1));
        in_carry    = 1'($urandom_range(0, 1));
        in_sign     = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
            0: begin
                in_mant = 27'h7FF_FFF8 | 27'($urandom_range(0, 7));
                in_exp  = 8'($urandom_range(250, 254));
            end
            1: begin
                in_mant = 27'($urandom) >> $urandom_range(0, 27);
                in_exp  = 8'($urandom_range(0, 30));
            end
            default: begin
                in_mant = 27'($urandom) >> $urandom_range(0, 27);
                in_exp  = 8'($urandom_range(0, 254));
            end
        endcase
    endtask

    initial begin
        bit fi;
        bit fo;
        int acc;
        int outs;

        add_vec("one_plus_one",  27'h000_0000, 1, 1, 0, 8'd127, 32'h4000_0000, 3'b000);
        add_vec("equal_sub",     27'h000_0000, 0, 0, 1, 8'd127, 32'h0000_0000, 3'b000);
        add_vec("add_zero_neg",  27'h000_0000, 0, 1, 1, 8'd5,   32'h8000_0000, 3'b000);
        add_vec("tie_lsb0",      27'h400_0004, 0, 1, 0, 8'd127, 32'h3F80_0000, 3'b001);
`ifdef FPU_NORM_RNE_EN
        add_vec("tie_lsb1",      27'h400_000C, 0, 1, 0, 8'd127, 32'h3F80_0002, 3'b001);
        add_vec("round_carry",   27'h7FF_FFFC, 0, 1, 0, 8'd127, 32'h4000_0000, 3'b001);
`else
        add_vec("tie_lsb1",      27'h400_000C, 0, 1, 0, 8'd127, 32'h3F80_0001, 3'b001);
        add_vec("round_carry",   27'h7FF_FFFC, 0, 1, 0, 8'd127, 32'h3FFF_FFFF, 3'b001);
`endif
        add_vec("overflow",      27'h7FF_FFF8, 1, 1, 0, 8'd254, 32'h7F80_0000, 3'b101);
        add_vec("cancel_uf",     27'h000_0008, 0, 0, 0, 8'd3,   32'h0000_0000, 3'b011);
        add_vec("neg_one",       27'h400_0000, 0, 0, 1, 8'd127, 32'hBF80_0000, 3'b000);
        add_vec("lz1",           27'h200_0000, 0, 0, 0, 8'd127, 32'h3F00_0000, 3'b000);
        add_vec("exp_min",       27'h400_0000, 0, 0, 0, 8'd1,   32'h0080_0000, 3'b000);
        add_vec("exp_zero_uf",   27'h400_0000, 0, 0, 1, 8'd0,   32'h8000_0000, 3'b011);
        add_vec("max_normal",    27'h400_0000, 0, 1, 0, 8'd254, 32'h7F00_0000, 3'b000);
        add_vec("exp255",        27'h400_0000, 0, 0, 1, 8'd255, 32'hFF80_0000, 3'b101);
        add_vec("carry_sticky",  27'h000_0003, 1, 1, 0, 8'd127, 32'h4000_0000, 3'b001);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_mant = '0; in_carry = 1'b0; in_add_path = 1'b0; in_sign = 1'b0; in_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {out_valid, out_flags, out_result}, 36'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_in_ready", 35'(in_ready), 35'd1);

        foreach (vq[i]) run_vec(vq[i]);

        // Backpressure: offer beats every cycle with the consumer stalled.
        out_ready = 1'b0;
        new_beat();
        in_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            if (c >= 2) begin
                check("bp_in_ready", 35'(in_ready), 35'd0);
                check("bp_out_valid", 35'(out_valid), 35'd1);
                if (sb.size() > 0) check("bp_hold", {out_flags, out_result}, sb[0]);
            end
            step(fi, fo);
            if (fi) begin
                acc++;
                new_beat();
            end
        end
        check("bp_accepts", 35'(acc), 35'd2);
        out_ready = 1'b1;
        outs = 0;
        for (int c = 0; c < 20 && (acc < 3 || sb.size() > 0); c++) begin
            step(fi, fo);
            if (fo) outs++;
            if (fi) begin
                acc++;
                if (acc < 3) new_beat();
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("bp_outputs", 35'(outs), 35'd3);

        // Randomized stream with random stalls on both sides.
        acc = 0;
        for (int c = 0; c < 6000 && acc < 300; c++) begin
            if (!in_valid && $urandom_range(0, 9) < 7) begin
                new_beat();
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 9) < 7);
            step(fi, fo);
            if (fi) begin
                acc++;
                if ($urandom_range(0, 9) < 7) new_beat();
                else in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("rand_accepts", 35'(acc), 35'd300);
        for (int c = 0; c < 10 && sb.size() > 0; c++) step(fi, fo);
        check("rand_drained", 35'(sb.size()), 35'd0);

        // Reset with both stages full.
        out_ready = 1'b0;
        new_beat();
        in_valid = 1'b1;
        step(fi, fo);
        new_beat();
        step(fi, fo);
        in_valid = 1'b0;
        check("rst_pre_valid", 35'(out_valid), 35'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", {out_valid, out_flags, out_result}, 36'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check("rst_quiet", 35'(out_valid), 35'd0);
            step(fi, fo);
        end
        run_vec(vq[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
